// File: rtl/ysyx_24110015_core_ctrl.sv
// ysyx_24110015_core_ctrl: multi-cycle fetch/exec/mem/writeback sequencer owning pc, commit and halt reporting
module ysyx_24110015_core_ctrl #(
  parameter int XLEN = 32,
  parameter int NR_REG = 16,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  localparam int AW = $clog2(NR_REG)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_inst,
  input  logic            ifu_rsp_err,
  output logic [31:0]     inst,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            ebreak,
  input  logic [XLEN-1:0] exu_result,
  input  logic [XLEN-1:0] exu_pc_next,
  output logic            lsu_req_valid,
  output logic            lsu_req_wen,
  input  logic            lsu_req_ready,
  input  logic            lsu_rsp_valid,
  input  logic [XLEN-1:0] lsu_rsp_rdata,
  output logic            rf_wen,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] pc,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_dnpc,
  output logic            halted,
  output logic [1:0]      halt_code
);
  typedef enum logic [2:0] {
    S_FETCH_REQ, S_FETCH_WAIT, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_WB, S_HALT
  } state_t;
  state_t          r_state;
  logic [XLEN-1:0] r_pc, r_pc_next, r_result, r_rdata;
  logic [31:0]     r_inst;
  logic [1:0]      r_code;
  logic            r_reg_write, r_mem_read, r_mem_write;
  logic            w_illegal;
  // RV32E only has x0..x15, so bit 4 of any used register field is a fault
  assign w_illegal = (NR_REG == 16) && ((reg_write && r_inst[11]) || r_inst[19] || r_inst[24]);
  // the request must not be visible while reset is held, even though the state already sits in FETCH_REQ
  assign ifu_req_valid = ~rst & (r_state == S_FETCH_REQ);
  assign ifu_req_addr  = r_pc;
  assign inst          = r_inst;
  assign lsu_req_valid = r_state == S_MEM_REQ;
  assign lsu_req_wen   = r_mem_write;
  assign rf_wen        = (r_state == S_WB) & r_reg_write;
  assign rf_waddr      = r_inst[7 +: AW];
  assign rf_wdata      = r_mem_read ? r_rdata : r_result;
  assign pc            = r_pc;
  assign commit_valid  = r_state == S_WB;
  assign commit_dnpc   = r_pc_next;
  assign halted        = r_state == S_HALT;
  assign halt_code     = r_code;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH_REQ;
      r_pc        <= RESET_PC;
      r_pc_next   <= '0;
      r_result    <= '0;
      r_rdata     <= '0;
      r_inst      <= '0;
      r_code      <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH_REQ: r_state <= ifu_req_ready ? S_FETCH_WAIT : S_FETCH_REQ;
        S_FETCH_WAIT: begin
          if (ifu_rsp_valid && ifu_rsp_err) begin
            r_state <= S_HALT;
            r_code  <= 2'd1;
          end else if (ifu_rsp_valid) begin
            r_state <= S_EXEC;
            r_inst  <= ifu_rsp_inst;
          end
        end
        S_EXEC: begin
          r_pc_next   <= exu_pc_next;
          r_result    <= exu_result;
          r_reg_write <= reg_write;
          r_mem_read  <= mem_read;
          r_mem_write <= mem_write;
          r_code      <= ebreak ? 2'd0 : 2'd2;
          r_state     <= (ebreak || w_illegal) ? S_HALT : (mem_read || mem_write) ? S_MEM_REQ : S_WB;
        end
        S_MEM_REQ: r_state <= lsu_req_ready ? S_MEM_WAIT : S_MEM_REQ;
        S_MEM_WAIT: begin
          if (lsu_rsp_valid) begin
            r_state <= S_WB;
            if (r_mem_read) r_rdata <= lsu_rsp_rdata;
          end
        end
        S_WB: begin
          r_pc    <= r_pc_next;
          r_state <= S_FETCH_REQ;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_FETCH_REQ;
      endcase
    end
  end
endmodule
